// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: captures a byte on load, builds an 11-bit frame
// (start, 7 data bits, two configurable trailing bits, stop) and shifts it out LSB first.
module uart_tx_ctrl #(
   parameter int unsigned BT_W   = 19,
   parameter int unsigned BT_MIN = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic [7:0]      out_port,
   input  logic            eight,
   input  logic            pen,
   input  logic            ohel,
   input  logic [BT_W-1:0] bit_time,
   output logic            tx,
   output logic            txrdy,
   output logic            tx_done
);

   typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

   state_e          state_q, state_d;
   logic [7:0]      data_q, data_d;
   logic            eight_q, eight_d;
   logic            pen_q, pen_d;
   logic            ohel_q, ohel_d;
   logic [BT_W-1:0] bt_q, bt_d;
   logic [10:0]     shr_q, shr_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [BT_W-1:0] bt_cnt_q, bt_cnt_d;
   logic            txrdy_q, txrdy_d;
   logic            tx_done_q, tx_done_d;

   logic            par;
   logic [1:0]      dec;
   logic [BT_W-1:0] bt_last;

   assign par     = ohel_q ? ~^data_q : ^data_q;
   assign bt_last = bt_q - BT_W'(1);

   always_comb begin
      unique case ({eight_q, pen_q})
         2'b00:   dec = 2'b11;
         2'b01:   dec = {1'b1, par};
         2'b10:   dec = {1'b1, data_q[7]};
         default: dec = {par, data_q[7]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      eight_d   = eight_q;
      pen_d     = pen_q;
      ohel_d    = ohel_q;
      bt_d      = bt_q;
      shr_d     = shr_q;
      bit_cnt_d = bit_cnt_q;
      bt_cnt_d  = bt_cnt_q;
      txrdy_d   = txrdy_q;
      tx_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            txrdy_d = 1'b1;
            if (load) begin
               data_d  = out_port;
               eight_d = eight;
               pen_d   = pen;
               ohel_d  = ohel;
               bt_d    = (bit_time < BT_W'(BT_MIN)) ? BT_W'(BT_MIN) : bit_time;
               txrdy_d = 1'b0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            shr_d     = {1'b1, dec[1], dec[0], data_q[6:0], 1'b0};
            bit_cnt_d = 4'd0;
            bt_cnt_d  = '0;
            state_d   = StSend;
         end
         StSend: begin
            if (bt_cnt_q == bt_last) begin
               bt_cnt_d = '0;
               // 1-fill leaves the register all ones, so tx idles high afterwards
               shr_d    = {1'b1, shr_q[10:1]};
               if (bit_cnt_q == 4'd10) begin
                  bit_cnt_d = 4'd0;
                  tx_done_d = 1'b1;
                  txrdy_d   = 1'b1;
                  state_d   = StIdle;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               bt_cnt_d = bt_cnt_q + BT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         data_q    <= 8'h00;
         eight_q   <= 1'b0;
         pen_q     <= 1'b0;
         ohel_q    <= 1'b0;
         bt_q      <= BT_W'(BT_MIN);
         shr_q     <= '1;
         bit_cnt_q <= 4'd0;
         bt_cnt_q  <= '0;
         txrdy_q   <= 1'b1;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         eight_q   <= eight_d;
         pen_q     <= pen_d;
         ohel_q    <= ohel_d;
         bt_q      <= bt_d;
         shr_q     <= shr_d;
         bit_cnt_q <= bit_cnt_d;
         bt_cnt_q  <= bt_cnt_d;
         txrdy_q   <= txrdy_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign tx      = shr_q[0];
   assign txrdy   = txrdy_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames from the examples plus
// randomized frames, checked cycle by cycle against a frame/timing reference model.
module tb_uart_tx_ctrl;

   localparam int unsigned BT_W   = 19;
   localparam int unsigned BT_MIN = 16;

   logic            clk;
   logic            reset_n;
   logic            load;
   logic [7:0]      out_port;
   logic            eight;
   logic            pen;
   logic            ohel;
   logic [BT_W-1:0] bit_time;
   logic            tx;
   logic            txrdy;
   logic            tx_done;

   int n_cmp;
   int n_err;

   uart_tx_ctrl #(
      .BT_W  (BT_W),
      .BT_MIN(BT_MIN)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .out_port(out_port),
      .eight   (eight),
      .pen     (pen),
      .ohel    (ohel),
      .bit_time(bit_time),
      .tx      (tx),
      .txrdy   (txrdy),
      .tx_done (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference frame: start, d0..d6, trailing bit A, trailing bit B, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                               input logic p, input logic o);
      logic        parity_bit;
      logic        bit_a;
      logic        bit_b;
      logic [10:0] f;
      // even parity: bit makes total ones even; odd parity: makes it odd
      parity_bit = (($countones(d) % 2) == 1) ? !o : o;
      if (!e && !p) begin
         bit_a = 1'b1; bit_b = 1'b1;
      end else if (!e && p) begin
         bit_a = parity_bit; bit_b = 1'b1;
      end else if (e && !p) begin
         bit_a = d[7]; bit_b = 1'b1;
      end else begin
         bit_a = d[7]; bit_b = parity_bit;
      end
      f[0] = 1'b0;
      for (int i = 0; i < 7; i++) f[i+1] = d[i];
      f[8]  = bit_a;
      f[9]  = bit_b;
      f[10] = 1'b1;
      return f;
   endfunction

   // Called at a negedge with the DUT able to accept load. Ends at the negedge
   // showing the tx_done pulse, so a caller may load again right away.
   task automatic run_frame(input string name, input logic [7:0] d, input logic e,
                            input logic p, input logic o, input int unsigned bt_in,
                            input bit disturb);
      logic [10:0] frame;
      int unsigned bt;
      int unsigned last;
      int unsigned dist_n;
      logic        exp_tx;
      frame    = model_frame(d, e, p, o);
      bt       = (bt_in < BT_MIN) ? BT_MIN : bt_in;
      last     = 1 + 11 * bt;
      dist_n   = $urandom_range(1, last - 1);
      load     = 1'b1;
      out_port = d;
      eight    = e;
      pen      = p;
      ohel     = o;
      bit_time = BT_W'(bt_in);
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      for (int n = 1; n <= int'(last); n++) begin
         if (n > 1) @(negedge clk);
         exp_tx = (n == 1) ? 1'b1 : frame[(n - 2) / bt];
         n_cmp++;
         if (tx !== exp_tx) begin
            n_err++;
            $display("FAIL %s tx cycle %0d: got %b want %b", name, n, tx, exp_tx);
         end
         n_cmp++;
         if (txrdy !== 1'b0) begin
            n_err++;
            $display("FAIL %s txrdy busy cycle %0d: got %b want 0", name, n, txrdy);
         end
         n_cmp++;
         if (tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s early tx_done cycle %0d: got %b want 0", name, n, tx_done);
         end
         if (disturb && n < int'(last)) begin
            out_port = 8'($urandom);
            eight    = 1'($urandom);
            pen      = 1'($urandom);
            ohel     = 1'($urandom);
            bit_time = BT_W'($urandom_range(0, 40));
            load     = (n == int'(dist_n));
            if (n == int'(dist_n)) out_port = 8'h55;
         end else begin
            load = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (tx_done !== 1'b1 || txrdy !== 1'b1 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL %s end {tx_done,txrdy,tx}: got %b%b%b want 111",
                  name, tx_done, txrdy, tx);
      end
   endtask

   task automatic idle_cycles(input int unsigned cnt);
      for (int i = 0; i < int'(cnt); i++) begin
         @(negedge clk);
         n_cmp++;
         if (tx !== 1'b1 || txrdy !== 1'b1 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL idle {tx,txrdy,tx_done}: got %b%b%b want 110", tx, txrdy, tx_done);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (tx !== 1'b1 || txrdy !== 1'b1 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset {tx,txrdy,tx_done}: got %b%b%b want 110", tx, txrdy, tx_done);
         end
      end
      reset_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_8n1();
      run_frame("8n1_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 16, 1'b0);
      idle_cycles(3);
   endtask

   task automatic test_7e1();
      run_frame("7e1_41", 8'h41, 1'b0, 1'b1, 1'b0, 16, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_8o1();
      run_frame("8o1_03", 8'h03, 1'b1, 1'b1, 1'b1, 20, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_busy_load();
      run_frame("busy_load", 8'hC3, 1'b1, 1'b1, 1'b0, 17, 1'b1);
      load = 1'b0;
      idle_cycles(4);
   endtask

   task automatic test_reset_mid();
      bit done_seen;
      bit tx_low;
      load     = 1'b1;
      out_port = 8'h00;
      eight    = 1'b1;
      pen      = 1'b0;
      ohel     = 1'b0;
      bit_time = BT_W'(16);
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      // walk into bit 4 of the frame
      for (int i = 0; i < 1 + 4 * 16 + 5; i++) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      n_cmp++;
      if (tx !== 1'b1 || txrdy !== 1'b1 || tx_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid {tx,txrdy,tx_done}: got %b%b%b want 110", tx, txrdy, tx_done);
      end
      done_seen = 1'b0;
      tx_low    = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) done_seen = 1'b1;
         if (tx !== 1'b1) tx_low = 1'b1;
      end
      n_cmp++;
      if (done_seen || tx_low) begin
         n_err++;
         $display("FAIL reset_mid abandoned: got done=%b txlow=%b want 0 0", done_seen, tx_low);
      end
      run_frame("after_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 16, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_back_to_back();
      run_frame("b2b_first", 8'h96, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      run_frame("b2b_second", 8'h3C, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      run_frame("b2b_third", 8'hE7, 1'b0, 1'b1, 1'b1, 18, 1'b0);
      idle_cycles(2);
   endtask

   task automatic test_random();
      for (int k = 0; k < 10; k++) begin
         run_frame("random", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 40), 1'($urandom));
         load = 1'b0;
         idle_cycles($urandom_range(0, 3));
      end
      idle_cycles(1);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      reset_n  = 1'b0;
      load     = 1'b0;
      out_port = 8'h00;
      eight    = 1'b0;
      pen      = 1'b0;
      ohel     = 1'b0;
      bit_time = '0;
      @(negedge clk);
      test_reset();
      test_8n1();
      test_7e1();
      test_8o1();
      test_busy_load();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
